tictactoe_nxn_mef: RTL

Parametrised game-control state machine for an N×N tic-tac-toe board, the successor of the fixed 3×3 controller. It sits between the synchronised push-button inputs and the VGA renderer. It owns the board registers, cursor, player turn, optional turn timer and win/draw detection, and exports the board as two occupancy vectors plus a one-cycle `load` strobe for the display.

---
 rtl/tictactoe_nxn_mef_pkg.sv | 21 ++
 rtl/tictactoe_nxn_mef_line_check.sv | 29 ++
 rtl/tictactoe_nxn_mef.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/tictactoe_nxn_mef_pkg.sv
// Shared types and constants for the N x N tic-tac-toe controller.
package tictactoe_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TURN_X = 3'd1,
        S_TURN_O = 3'd2,
        S_CHECK  = 3'd3,
        S_WIN    = 3'd4,
        S_DRAW   = 3'd5
    } state_t;

    localparam logic PL_X = 1'b0;
    localparam logic PL_O = 1'b1;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_X    = 2'b01;
    localparam logic [1:0] WIN_O    = 2'b10;
    localparam logic [1:0] WIN_DRAW = 2'b11;

endpackage

// File: rtl/tictactoe_nxn_mef_line_check.sv
// Combinational detector: any full row, column or diagonal in one player's N x N occupancy map.
module ttt_line_check #(
    parameter int N = 3
) (
    input  logic [N*N-1:0] cells,
    output logic           line
);

    logic [N-1:0] row_full;
    logic [N-1:0] col_full;
    logic [N-1:0] diag_bits;
    logic [N-1:0] anti_bits;

    for (genvar r = 0; r < N; r++) begin : g_line
        logic [N-1:0] row_bits;
        logic [N-1:0] col_bits;
        for (genvar c = 0; c < N; c++) begin : g_cell
            assign row_bits[c] = cells[r*N + c];
            assign col_bits[c] = cells[c*N + r];
        end
        assign row_full[r]  = &row_bits;
        assign col_full[r]  = &col_bits;
        assign diag_bits[r] = cells[r*N + r];
        assign anti_bits[r] = cells[r*N + (N-1-r)];
    end

    assign line = (|row_full) | (|col_full) | (&diag_bits) | (&anti_bits);

endmodule

// File: rtl/tictactoe_nxn_mef.sv
// N x N tic-tac-toe game controller: board, cursor, turn, win/draw detection.
// Define TTT_TIMER_EN to add a per-turn expiry timer of TURN_CYCLES clocks.
module tictactoe_nxn_mef
    import tictactoe_pkg::*;
#(
    parameter int N           = 3,
    parameter int TURN_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   I,
    input  logic                   W,
    input  logic                   T,
    output logic [2:0]             estado,
    output logic [$clog2(N*N)-1:0] cursor,
    output logic                   turn,
    output logic [N*N-1:0]         board_x,
    output logic [N*N-1:0]         board_o,
    output logic [1:0]             winner,
    output logic                   load,
    output logic                   timeout
);

    localparam int CELLS = N * N;
    localparam int CW    = $clog2(CELLS);
    localparam logic [CW-1:0] LAST_CELL = CW'(CELLS - 1);

    if (N < 3 || N > 5 || TURN_CYCLES < 4) begin : g_bad_params
        $error("tictactoe_nxn_mef: N must be 3..5 and TURN_CYCLES at least 4");
    end

    state_t           state, state_nxt;
    logic [CW-1:0]    cursor_nxt;
    logic             turn_nxt;
    logic [CELLS-1:0] bx_nxt, bo_nxt;
    logic [1:0]       winner_nxt;
    logic             load_nxt;

    logic i_q, w_q;
    logic i_rise, w_fall;
    logic [CELLS-1:0] occupied, mover_cells;
    logic line, cell_free, place_ok, board_full, expire;

    assign i_rise = I & ~i_q;
    assign w_fall = ~W & w_q;

    assign occupied    = board_x | board_o;
    assign cell_free   = ~occupied[cursor];
    assign place_ok    = w_fall & cell_free;
    assign board_full  = &occupied;
    // In CHECK the turn has not toggled yet, so this is the player who just moved.
    assign mover_cells = (turn == PL_O) ? board_o : board_x;

    ttt_line_check #(.N(N)) u_line_check (
        .cells (mover_cells),
        .line  (line)
    );

`ifdef TTT_TIMER_EN
    localparam int TW = $clog2(TURN_CYCLES);
    localparam logic [TW-1:0] TIMER_RELOAD = TW'(TURN_CYCLES - 1);

    logic [TW-1:0] timer, timer_nxt;
    logic          timeout_nxt;

    assign expire = (timer == '0);
`else
    assign expire  = 1'b0;
    assign timeout = 1'b0;
`endif

    assign estado = state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= S_IDLE;
            i_q     <= 1'b0;
            w_q     <= 1'b1;
            cursor  <= '0;
            turn    <= PL_X;
            board_x <= '0;
            board_o <= '0;
            winner  <= WIN_NONE;
            load    <= 1'b0;
`ifdef TTT_TIMER_EN
            timer   <= TIMER_RELOAD;
            timeout <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            i_q     <= I;
            w_q     <= W;
            cursor  <= cursor_nxt;
            turn    <= turn_nxt;
            board_x <= bx_nxt;
            board_o <= bo_nxt;
            winner  <= winner_nxt;
            load    <= load_nxt;
`ifdef TTT_TIMER_EN
            timer   <= timer_nxt;
            timeout <= timeout_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt = state;
        if (T) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (w_fall) state_nxt = S_TURN_X;
                end
                S_TURN_X, S_TURN_O: begin
                    if (place_ok)
                        state_nxt = S_CHECK;
                    else if (expire)
                        state_nxt = (state == S_TURN_X) ? S_TURN_O : S_TURN_X;
                end
                S_CHECK: begin
                    if (line)
                        state_nxt = S_WIN;
                    else if (board_full)
                        state_nxt = S_DRAW;
                    else
                        state_nxt = (turn == PL_X) ? S_TURN_O : S_TURN_X;
                end
                S_WIN, S_DRAW: state_nxt = state;
                default:       state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cursor_nxt = cursor;
        turn_nxt   = turn;
        bx_nxt     = board_x;
        bo_nxt     = board_o;
        winner_nxt = winner;
        load_nxt   = 1'b0;
`ifdef TTT_TIMER_EN
        timer_nxt   = timer;
        timeout_nxt = 1'b0;
`endif
        if (T) begin
            cursor_nxt = '0;
            turn_nxt   = PL_X;
            bx_nxt     = '0;
            bo_nxt     = '0;
            winner_nxt = WIN_NONE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (w_fall) begin
                        cursor_nxt = '0;
`ifdef TTT_TIMER_EN
                        timer_nxt  = TIMER_RELOAD;
`endif
                    end
                end
                S_TURN_X, S_TURN_O: begin
                    if (place_ok) begin
                        if (turn == PL_O)
                            bo_nxt[cursor] = 1'b1;
                        else
                            bx_nxt[cursor] = 1'b1;
                        load_nxt = 1'b1;
                    end else begin
                        // A confirm press, even on an occupied cell, swallows the advance.
                        if (i_rise && !w_fall)
                            cursor_nxt = (cursor == LAST_CELL) ? '0 : cursor + CW'(1);
`ifdef TTT_TIMER_EN
                        if (expire) begin
                            timeout_nxt = 1'b1;
                            turn_nxt    = ~turn;
                            timer_nxt   = TIMER_RELOAD;
                        end else begin
                            timer_nxt   = timer - TW'(1);
                        end
`endif
                    end
                end
                S_CHECK: begin
                    if (line) begin
                        winner_nxt = (turn == PL_O) ? WIN_O : WIN_X;
                    end else if (board_full) begin
                        winner_nxt = WIN_DRAW;
                    end else begin
                        turn_nxt   = ~turn;
`ifdef TTT_TIMER_EN
                        timer_nxt  = TIMER_RELOAD;
`endif
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
